// File: rtl/dot_product_scheduler.sv
// rtl/dot_product_scheduler.sv - round-robin scheduler sharing one dot-product engine among NUM_REQ requesters
//
// Optional feature: define DOTP_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog
// (TIMEOUT_CYCLES WAIT cycles without eng_done -> sticky timeout_err, zero result).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[NUM_REQ]      per-requester request, held until req_ready
//   req_a, req_b            packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready[NUM_REQ]      one-hot accept pulse (ISSUE cycle)
//   rsp_valid[NUM_REQ]      one-hot result pulse to the owning requester (RESP cycle)
//   rsp_result              result of the most recently completed job, held
//   eng_start               one-cycle engine start pulse
//   eng_a, eng_b            registered engine operands
//   eng_result, eng_done    engine result and completion flag
//   busy                    high whenever the FSM is not IDLE
//   timeout_err             sticky watchdog flag (constant 0 without the macro)

module dot_product_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int RESULT_WIDTH   = 16,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [RESULT_WIDTH-1:0]       rsp_result,
  output logic                          eng_start,
  output logic [DATA_WIDTH-1:0]         eng_a,
  output logic [DATA_WIDTH-1:0]         eng_b,
  input  logic [RESULT_WIDTH-1:0]       eng_result,
  input  logic                          eng_done,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  logic [DATA_WIDTH-1:0] a_slot [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_slot [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_slot[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_slot[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // (base + offset) mod NUM_REQ without a divider; offset is always < NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_index(ptr, k)]) begin
        pick_idx = rr_index(ptr, k);
        pick_any = 1'b1;
      end
    end
  end

`ifdef DOTP_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      eng_a       <= '0;
      eng_b       <= '0;
      rsp_result  <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      eng_start   <= 1'b0;
      busy        <= 1'b0;
`ifdef DOTP_SCHED_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // Pulses are set only on the transition into the state that owns them.
      req_ready <= '0;
      rsp_valid <= '0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant     <= pick_idx;
            eng_a     <= a_slot[pick_idx];
            eng_b     <= b_slot[pick_idx];
            req_ready <= onehot(pick_idx);
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef DOTP_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            rsp_result <= eng_result;
            rsp_valid  <= onehot(grant);
            state      <= RESP;
          end
`ifdef DOTP_SCHED_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            rsp_result  <= '0;
            rsp_valid   <= onehot(grant);
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          ptr   <= rr_index(grant, 1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
